// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO bus decoder: FSM encoding and default
// address-field positions.
package mmio_pkg;

    localparam int IO_BIT_DEF = 29;
    localparam int SEL_LO_DEF = 26;
    localparam int SEL_W_DEF  = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

endpackage

// File: rtl/mmio_timeout_ctr.sv
// Wait-cycle counter for I/O accesses; expired flags the last permitted
// WAIT cycle so the FSM can leave for ERR on the following edge.
module mmio_timeout_ctr (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [15:0] limit,
    output logic        expired
);

    logic [15:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != 16'hFFFF) begin
            count <= count + 16'd1;
        end
    end

    // This cycle's increment would bring the count to the limit.
    assign expired = enable && (({1'b0, count} + 17'd1) >= {1'b0, limit});

endmodule

// File: rtl/mmio_bus_decoder.sv
// Processor bus decoder: memory region passes straight through, the I/O
// region is routed to one of NUM_SLAVES channels through a small FSM.
module mmio_bus_decoder
    import mmio_pkg::*;
#(
    parameter int NUM_SLAVES = 6,
    parameter int SEL_W      = SEL_W_DEF,
    parameter int SEL_LO     = SEL_LO_DEF,
    parameter int IO_BIT     = IO_BIT_DEF,
    parameter int TIMEOUT    = 255
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [29:0]              m_addr,
    input  logic [31:0]              m_wdata,
    input  logic [3:0]               m_we,
    input  logic                     m_read,
    output logic [31:0]              m_rdata,
    output logic                     m_ready,
    output logic                     m_buserr,
    output logic                     mem_re,
    output logic [3:0]               mem_we,
    input  logic [31:0]              mem_rdata,
    input  logic                     mem_ready,
    output logic [NUM_SLAVES-1:0]    s_re,
    output logic [4*NUM_SLAVES-1:0]  s_we,
    input  logic [32*NUM_SLAVES-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]    s_ready,
    output logic                     err_irq,
    output logic [29:0]              err_addr,
    input  logic                     err_clr,
    output logic [1:0]               fsm_state
);

    // Handshake: the processor holds m_addr/m_read/m_we stable until it sees
    // m_ready; a slave holds s_ready until its strobe drops.
    logic             is_io, io_req, idx_ok, sel_ready, expired, err_entry;
    logic [SEL_W-1:0] idx, idx_q;
    logic [1:0]       state, state_n;
    logic             read_q;
    logic [3:0]       we_q;
    logic [29:0]      addr_q;
    logic [31:0]      rdata_q, sel_rdata;
    logic             unused_wdata;

    assign unused_wdata = ^m_wdata;
    assign is_io        = m_addr[IO_BIT];
    assign io_req       = is_io & (m_read | (|m_we));
    assign idx          = m_addr[SEL_LO+SEL_W-1:SEL_LO];
    assign idx_ok       = (32'(idx) < 32'(NUM_SLAVES));
    assign fsm_state    = state;

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        s_re      = '0;
        s_we      = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == SEL_W'(i)) begin
                sel_ready = s_ready[i];
                sel_rdata = s_rdata[32*i +: 32];
                if (state == ST_WAIT) begin
                    s_re[i]        = read_q;
                    s_we[4*i +: 4] = we_q;
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (io_req) state_n = idx_ok ? ST_WAIT : ST_ERR;
            ST_WAIT: begin
                if (!io_req || m_addr != addr_q) state_n = ST_IDLE;
                else if (sel_ready)              state_n = ST_RESP;
                else if (expired)                state_n = ST_ERR;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign err_entry = (state != ST_ERR) && (state_n == ST_ERR);

    mmio_timeout_ctr u_timeout_ctr (
        .clock   (clock),
        .reset   (reset),
        .clear   (state == ST_IDLE),
        .enable  (state == ST_WAIT),
        .limit   (16'(TIMEOUT)),
        .expired (expired)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            idx_q    <= '0;
            read_q   <= 1'b0;
            we_q     <= '0;
            addr_q   <= '0;
            rdata_q  <= '0;
            err_irq  <= 1'b0;
            err_addr <= '0;
        end else begin
            state <= state_n;
            if (state == ST_IDLE && io_req) begin
                idx_q  <= idx;
                read_q <= m_read;
                we_q   <= m_we;
                addr_q <= m_addr;
            end
            if (state == ST_WAIT && state_n == ST_RESP)
                rdata_q <= read_q ? sel_rdata : 32'd0;
            // A bad index errors straight from IDLE, before addr_q is loaded.
            if (err_entry && !err_irq)
                err_addr <= (state == ST_IDLE) ? m_addr : addr_q;
            if (err_entry)
                err_irq <= 1'b1;
            else if (err_clr)
                err_irq <= 1'b0;
        end
    end

    always_comb begin
        if (!is_io) begin
            mem_re   = m_read;
            mem_we   = m_we;
            m_rdata  = mem_rdata;
            m_ready  = mem_ready;
            m_buserr = 1'b0;
        end else begin
            mem_re   = 1'b0;
            mem_we   = '0;
            m_rdata  = (state == ST_RESP) ? rdata_q : 32'd0;
            m_ready  = (state == ST_RESP) || (state == ST_ERR);
            m_buserr = (state == ST_ERR);
        end
    end

endmodule

// File: tb/tb_mmio_bus_decoder.sv
// Directed bench for mmio_bus_decoder (NUM_SLAVES=6, TIMEOUT=8).
module tb_mmio_bus_decoder;

    localparam int NS = 6;

    logic          clock = 1'b0;
    logic          reset;
    logic [29:0]   m_addr;
    logic [31:0]   m_wdata;
    logic [3:0]    m_we;
    logic          m_read;
    logic [31:0]   m_rdata;
    logic          m_ready, m_buserr;
    logic          mem_re;
    logic [3:0]    mem_we;
    logic [31:0]   mem_rdata;
    logic          mem_ready;
    logic [NS-1:0]    s_re;
    logic [4*NS-1:0]  s_we;
    logic [32*NS-1:0] s_rdata;
    logic [NS-1:0]    s_ready;
    logic          err_irq;
    logic [29:0]   err_addr;
    logic          err_clr;
    logic [1:0]    fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    mmio_bus_decoder #(.NUM_SLAVES(NS), .TIMEOUT(8)) dut (
        .clock(clock), .reset(reset),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_read(m_read),
        .m_rdata(m_rdata), .m_ready(m_ready), .m_buserr(m_buserr),
        .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .s_re(s_re), .s_we(s_we), .s_rdata(s_rdata), .s_ready(s_ready),
        .err_irq(err_irq), .err_addr(err_addr), .err_clr(err_clr),
        .fsm_state(fsm_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clock);
        #2;
    endtask

    initial begin
        reset = 1'b1; m_addr = 30'h2000_0000; m_wdata = '0; m_we = '0; m_read = 1'b0;
        mem_rdata = '0; mem_ready = 1'b0; s_rdata = '0; s_ready = '0; err_clr = 1'b0;
        #23;
        chk("rst_m_ready", 32'(m_ready), 0);
        chk("rst_m_buserr", 32'(m_buserr), 0);
        chk("rst_m_rdata", m_rdata, 0);
        chk("rst_s_re", 32'(s_re), 0);
        chk("rst_s_we", 32'(s_we), 0);
        chk("rst_err_irq", 32'(err_irq), 0);
        chk("rst_err_addr", 32'(err_addr), 0);
        chk("rst_state", 32'(fsm_state), 0);
        reset = 1'b0;
        next_cycle();

        // Read slave 3, stray ack from slave 1 first, real ack two cycles on.
        m_addr = 30'h2C00_0000; m_read = 1'b1;
        #1 chk("rd3_mem_re", 32'(mem_re), 0);
        next_cycle();
        chk("rd3_w1_state", 32'(fsm_state), 1);
        chk("rd3_w1_s_re", 32'(s_re), 32'b001000);
        chk("rd3_w1_s_we", 32'(s_we), 0);
        s_ready[1] = 1'b1; s_rdata[63:32] = 32'hDEAD_BEEF;
        next_cycle();
        chk("rd3_stray_state", 32'(fsm_state), 1);
        chk("rd3_w2_m_ready", 32'(m_ready), 0);
        s_ready = 6'b001000; s_rdata[127:96] = 32'h0001_2345;
        next_cycle();
        s_ready = '0;
        #1;
        chk("rd3_m_ready", 32'(m_ready), 1);
        chk("rd3_m_rdata", m_rdata, 32'h0001_2345);
        chk("rd3_m_buserr", 32'(m_buserr), 0);
        chk("rd3_resp_s_re", 32'(s_re), 0);
        m_read = 1'b0;
        next_cycle();
        chk("rd3_done_ready", 32'(m_ready), 0);
        chk("rd3_done_state", 32'(fsm_state), 0);

        // Write slave 4 with no ack: ERR after 8 WAIT cycles.
        m_addr = 30'h3000_0000; m_we = 4'hF; m_wdata = 32'hA5A5_5A5A;
        next_cycle();
        chk("to_w1_s_we", 32'(s_we), 32'h000F_0000);
        chk("to_w1_s_re", 32'(s_re), 0);
        for (int k = 2; k <= 8; k++) begin
            next_cycle();
            chk("to_wait_state", 32'(fsm_state), 1);
            chk("to_wait_ready", 32'(m_ready), 0);
        end
        next_cycle();
        chk("to_m_ready", 32'(m_ready), 1);
        chk("to_m_buserr", 32'(m_buserr), 1);
        chk("to_m_rdata", m_rdata, 0);
        chk("to_s_we", 32'(s_we), 0);
        chk("to_err_irq", 32'(err_irq), 1);
        chk("to_err_addr", 32'(err_addr), 32'h3000_0000);
        m_we = '0;
        next_cycle();
        chk("to_idle_ready", 32'(m_ready), 0);
        chk("to_idle_buserr", 32'(m_buserr), 0);
        chk("to_irq_sticky", 32'(err_irq), 1);

        // Clear, then an out-of-range index errors immediately.
        err_clr = 1'b1;
        next_cycle();
        err_clr = 1'b0;
        chk("clr_err_irq", 32'(err_irq), 0);
        chk("clr_err_addr_kept", 32'(err_addr), 32'h3000_0000);
        m_addr = 30'h3800_0000; m_read = 1'b1;
        #1 chk("bad_idle_s_re", 32'(s_re), 0);
        next_cycle();
        chk("bad_m_ready", 32'(m_ready), 1);
        chk("bad_m_buserr", 32'(m_buserr), 1);
        chk("bad_m_rdata", m_rdata, 0);
        chk("bad_s_re", 32'(s_re), 0);
        chk("bad_err_irq", 32'(err_irq), 1);
        chk("bad_err_addr", 32'(err_addr), 32'h3800_0000);
        m_read = 1'b0;
        next_cycle();

        // Second error coincident with err_clr: flag stays, address kept.
        m_addr = 30'h3C00_0000; m_read = 1'b1; err_clr = 1'b1;
        next_cycle();
        m_read = 1'b0; err_clr = 1'b0;
        chk("dbl_m_buserr", 32'(m_buserr), 1);
        chk("dbl_err_irq", 32'(err_irq), 1);
        chk("dbl_err_addr", 32'(err_addr), 32'h3800_0000);
        next_cycle();
        chk("dbl_after_irq", 32'(err_irq), 1);

        // Memory region pass-through.
        m_addr = 30'h0000_0010; m_read = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
        #1;
        chk("mem_re", 32'(mem_re), 1);
        chk("mem_m_ready", 32'(m_ready), 1);
        chk("mem_m_rdata", m_rdata, 32'hCAFE_F00D);
        chk("mem_buserr", 32'(m_buserr), 0);
        chk("mem_s_re", 32'(s_re), 0);
        next_cycle();
        chk("mem_state_idle", 32'(fsm_state), 0);
        m_read = 1'b0; m_we = 4'h5; mem_ready = 1'b0;
        #1;
        chk("mem_we", 32'(mem_we), 5);
        chk("mem_ready_low", 32'(m_ready), 0);
        m_we = '0;
        next_cycle();

        // Request dropped mid-WAIT aborts without m_ready.
        m_addr = 30'h2000_0000; m_read = 1'b1;
        next_cycle();
        chk("abort_w1_s_re", 32'(s_re), 32'b000001);
        m_read = 1'b0;
        next_cycle();
        chk("abort_state", 32'(fsm_state), 0);
        chk("abort_ready", 32'(m_ready), 0);

        // Reset mid-WAIT clears everything asynchronously.
        m_addr = 30'h2800_0000; m_read = 1'b1;
        next_cycle();
        chk("rstw_s_re", 32'(s_re), 32'b000100);
        reset = 1'b1;
        #1;
        chk("rstw_s_re_0", 32'(s_re), 0);
        chk("rstw_m_ready", 32'(m_ready), 0);
        chk("rstw_err_irq", 32'(err_irq), 0);
        chk("rstw_err_addr", 32'(err_addr), 0);
        chk("rstw_state", 32'(fsm_state), 0);
        m_read = 1'b0;
        next_cycle();
        reset = 1'b0;
        s_ready = 6'b000100;
        next_cycle();
        chk("rstw_post_ready1", 32'(m_ready), 0);
        s_ready = '0;
        next_cycle();
        chk("rstw_post_ready2", 32'(m_ready), 0);
        chk("rstw_post_state", 32'(fsm_state), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
